// File: rtl/bk_prefix_adder_pipe_if.sv
// Operand/result bundle for the pipelined Brent-Kung adder; master is the
// producer/consumer side, slave is the adder.
interface bk_prefix_adder_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/bk_prefix_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with tag sideband; fixed latency of STAGES cycles.
// Per-stage valid/enable chain: empty stages always load, full pipe stalls on out_ready=0.
module bk_prefix_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  bk_prefix_adder_pipe_if.slave bus
);
  localparam int LOG    = $clog2(WIDTH);
  localparam int LEVELS = 2 * LOG - 1;

  // pi is kept apart from p because the tree overwrites p with group propagates
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] pi;
    logic             c0;
    logic [TAG_W-1:0] tag;
  } chain_t;

  function automatic chain_t f_level(input chain_t s, input int lvl);
    chain_t o;
    int     d;
    o = s;
    if (lvl <= LOG) d = 1 << (lvl - 1);
    else            d = 1 << (2 * LOG - 1 - lvl);
    for (int i = 0; i < WIDTH; i++) begin
      if (((lvl <= LOG) && (((i + 1) % (2 * d)) == 0)) ||
          ((lvl > LOG) && (((i + 1) % (2 * d)) == d) && ((i + 1) > 2 * d))) begin
        o.g[i] = s.g[i] | (s.p[i] & s.g[i-d]);
        o.p[i] = s.p[i] & s.p[i-d];
      end
    end
    return o;
  endfunction

  function automatic chain_t f_levels(input chain_t s, input int lo, input int hi);
    chain_t o;
    o = s;
    for (int l = 1; l <= LEVELS; l++) begin
      if ((l > lo) && (l <= hi)) o = f_level(o, l);
    end
    return o;
  endfunction

  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  chain_t           w_pre;
  chain_t           w_st [STAGES];

  // Carry-in is folded into bit 0, so the tree output g[i] is the carry out of bit i
  always_comb begin
    w_pre     = '0;
    w_bx      = bus.in_sub ? ~bus.in_b : bus.in_b;
    w_c0      = bus.in_sub | bus.in_cin;
    w_pre.pi  = bus.in_a ^ w_bx;
    w_pre.p   = w_pre.pi;
    w_pre.p[0] = 1'b0;
    w_pre.g   = bus.in_a & w_bx;
    w_pre.g[0] = w_pre.g[0] | (w_pre.pi[0] & w_c0);
    w_pre.c0  = w_c0;
    w_pre.tag = bus.in_tag;
  end

  assign w_st[0] = w_pre;

  logic [STAGES:1]   r_vld;
  logic [STAGES+1:1] w_en;
  logic [STAGES:1]   w_vin;

  always_comb begin
    w_en           = '0;
    w_en[STAGES+1] = bus.out_ready;
    for (int k = STAGES; k >= 1; k--) w_en[k] = ~r_vld[k] | w_en[k+1];
  end

  always_comb begin
    w_vin    = '0;
    w_vin[1] = bus.in_valid;
    for (int k = 2; k <= STAGES; k++) w_vin[k] = r_vld[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (w_en[k]) r_vld[k] <= w_vin[k];
      end
    end
  end

  assign bus.in_ready = w_en[1];

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    localparam int LO = ((k - 1) * LEVELS) / STAGES;
    localparam int HI = (k * LEVELS) / STAGES;
    chain_t w_nxt;
    chain_t r_st;

    always_comb w_nxt = f_levels(w_st[k-1], LO, HI);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_st <= '0;
      else if (w_en[k] && w_vin[k]) r_st <= w_nxt;
    end

    assign w_st[k] = r_st;
  end

  localparam int LO_F = ((STAGES - 1) * LEVELS) / STAGES;

  chain_t           w_fin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_unused_p;

  always_comb begin
    w_fin  = f_levels(w_st[STAGES-1], LO_F, LEVELS);
    w_sum  = w_fin.pi ^ {w_fin.g[WIDTH-2:0], w_fin.c0};
    w_cout = w_fin.g[WIDTH-1];
    w_ovf  = w_fin.g[WIDTH-1] ^ w_fin.g[WIDTH-2];
  end

  assign w_unused_p = ^w_fin.p;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [TAG_W-1:0] r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_tag  <= '0;
    end else if (w_en[STAGES] && w_vin[STAGES]) begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
      r_tag  <= w_fin.tag;
    end
  end

  assign bus.out_valid = r_vld[STAGES];
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_tag   = r_tag;
endmodule

// File: tb/tb_bk_prefix_adder_pipe.sv
// Scoreboard bench for bk_prefix_adder_pipe: directed arithmetic corners, backpressure,
// bubbles, mid-stream reset and a random valid/ready soak against an A+b'+c0 model.
module tb_bk_prefix_adder_pipe;
  localparam int WIDTH  = 16;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

  typedef logic [WIDTH+TAG_W+1:0] res_t;
  typedef logic [WIDTH+TAG_W+2:0] snap_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bk_prefix_adder_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  bk_prefix_adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  res_t sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, input logic [TAG_W-1:0] tag);
    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [WIDTH:0]   r;
    logic             ovf;
    bx  = sub ? ~b : b;
    c0  = sub | cin;
    r   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, c0};
    ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    return {r[WIDTH-1:0], r[WIDTH], ovf, tag};
  endfunction

  function automatic snap_t snap();
    return {bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag};
  endfunction

  // Monitor: handshakes are judged mid-cycle, so they describe the coming edge
  initial begin
    bit    hold;
    snap_t held;
    snap_t cur;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        hold = 1'b0;
      end else begin
        cur = snap();
        if (hold) chk("stall_hold", cur, held);
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          if (sb.size() == 0) chk("stale_beat", bus.out_valid, 1'b0);
          else chk("result", {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag}, sb.pop_front());
        end
        hold = bus.out_valid && !bus.out_ready;
        held = cur;
        if (bus.in_valid && bus.in_ready)
          sb.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub, bus.in_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input logic [TAG_W-1:0] tag);
    bit done;
    done         = 1'b0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    if (!done) chk("accept_timeout", bus.in_ready, 1'b1);
  endtask

  task automatic run_one(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input logic [TAG_W-1:0] tag,
                         input logic [WIDTH-1:0] e_sum, input logic e_cout, input logic e_ovf);
    int edges;
    bit got;
    bus.out_ready = 1'b1;
    send(a, b, cin, sub, tag);
    bus.in_valid = 1'b0;
    edges = 0;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    chk({name, "_latency"}, edges, STAGES - 1);
    chk(name, {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag}, {e_sum, e_cout, e_ovf, tag});
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [TAG_W-1:0] bp_tag [4];
    int               pat [8];
    bit               obs [8];
    int               n_start;

    bp_tag = '{4'h1, 4'h2, 4'h3, 4'h4};
    pat    = '{1, 0, 1, 0, 1, 0, 0, 0};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", snap(), '0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    run_one("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h5, 16'h0000, 1'b1, 1'b0);
    run_one("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 4'h6, 16'h7FFF, 1'b1, 1'b1);
    run_one("sub_borrow",  16'h0003, 16'h0005, 1'b0, 1'b1, 4'h7, 16'hFFFE, 1'b0, 1'b0);
    run_one("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h8, 16'h8000, 1'b0, 1'b1);
    run_one("add_cin",     16'h1234, 16'h0001, 1'b1, 1'b0, 4'h9, 16'h1236, 1'b0, 1'b0);
    run_one("sub_cin_ign", 16'h0005, 16'h0003, 1'b1, 1'b1, 4'hA, 16'h0002, 1'b1, 1'b0);

    // Backpressure: three beats fill the pipe, the fourth waits for the first to drain
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), bp_tag[i]);
    bus.in_a   = 16'($urandom);
    bus.in_b   = 16'($urandom);
    bus.in_tag = bp_tag[3];
    @(negedge clk);
    chk("bp_full_in_ready", bus.in_ready, 1'b0);
    chk("bp_head", {bus.out_valid, bus.out_tag}, {1'b1, bp_tag[0]});
    tick();
    @(negedge clk);
    chk("bp_still_full", bus.in_ready, 1'b0);
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_chain", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      chk("bp_order", {bus.out_valid, bus.out_tag}, {1'b1, bp_tag[j]});
      tick();
    end
    @(negedge clk);
    chk("bp_empty", bus.out_valid, 1'b0);
    tick();

    // Reset with three beats in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'(i + 11));
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", snap(), '0);
    chk("rst_mid_in_ready", bus.in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_stale", bus.out_valid, 1'b0);
      tick();
    end

    // Bubbles propagate unchanged, two edges after the accepting edge
    for (int n = 0; n < 8; n++) begin
      bus.in_valid = pat[n][0];
      bus.in_a     = 16'($urandom);
      bus.in_b     = 16'($urandom);
      bus.in_cin   = 1'($urandom);
      bus.in_sub   = 1'($urandom);
      bus.in_tag   = 4'(n);
      @(negedge clk);
      obs[n] = bus.out_valid;
      tick();
    end
    for (int n = 0; n < 8; n++)
      chk("bubble_shift", obs[n], (n >= STAGES) ? pat[n-STAGES][0] : 1'b0);

    // Same pattern with a two-cycle output stall: bubbles collapse, nothing lost
    n_start = n_out;
    for (int n = 0; n < 8; n++) begin
      bus.in_valid  = pat[n][0];
      bus.out_ready = !(n == 2 || n == 3);
      bus.in_a      = 16'($urandom);
      bus.in_b      = 16'($urandom);
      bus.in_tag    = 4'(n);
      @(negedge clk);
      if (pat[n] != 0) chk("bubble_accept", bus.in_ready, 1'b1);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk("bubble_stall_count", n_out - n_start, 3);
    chk("bubble_stall_drained", sb.size(), 0);

    // Random soak
    for (int c = 0; c < 20000; c++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_a      = 16'($urandom);
      bus.in_b      = 16'($urandom);
      bus.in_cin    = 1'($urandom);
      bus.in_sub    = 1'($urandom);
      bus.in_tag    = 4'($urandom);
      bus.out_ready = 1'($urandom);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("final_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
